count_run_ctrl: RTL and testbench
=================================

// Module: count_run_ctrl
// PURPOSE
//   Run/pause/clear sequencer for the BCD counter datapath; replaces the free-running 1 Hz clock.
//   Debounces the user buttons and issues a single-cycle count enable at TICK_HZ.
//   Also drives a synchronous clear and a display-hold (lap) flag.
//   Sits between the board buttons and the digits counter / seg7_control, all in the clk_50MHz domain.
// PARAMETERS
//   CLK_HZ       50_000_000  input clock frequency
//   TICK_HZ      1           count-enable rate; localparam DIV = CLK_HZ/TICK_HZ (DIV >= 2)
//   DB_CYCLES    500_000     consecutive stable samples needed to accept a button level (10 ms)
//   STOP_AT_MAX  1           1: halt in DONE at terminal count; 0: let the datapath wrap 99->00
// PORTS
//   clk_50MHz   in   1  system clock, all logic on rising edge
//   reset       in   1  synchronous, active-high
//   btn_start   in   1  raw start/pause button, asynchronous, bouncy
//   btn_clear   in   1  raw clear button, asynchronous, bouncy
//   btn_lap     in   1  raw lap (display freeze) button, asynchronous, bouncy
//   count_tc    in   1  datapath at terminal count (99), level
//   tick_en     out  1  one-cycle count enable to the counter
//   count_clr   out  1  one-cycle synchronous clear to the counter
//   disp_hold   out  1  level; 1 = display keeps last latched value
//   state       out  2  current FSM state (encoding below)
// BEHAVIOUR
//   Reset: state=IDLE, tick_en=0, count_clr=0, disp_hold=0.
//     Reset also clears: divider=0, all sync FFs/debounce counters/debounced levels=0.
//     Reset mid-operation returns to IDLE at that edge. No count_clr is issued; the datapath has its own reset.
//   Input path, per button:
//     - 2-FF synchronizer.
//     - Debounce counter: the debounced level db takes the synchronized value once it has differed
//       from db for DB_CYCLES consecutive cycles. Any sample equal to db resets the counter to 0.
//     - press = db rising edge, registered, 1 cycle wide. Falling edges are ignored.
//   FSM (encoding): IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11.
//     Transitions take effect the cycle after the press pulse.
//     - clear press, any state -> IDLE. count_clr=1 for exactly 1 cycle, divider=0, disp_hold=0.
//       Clear has priority over start/lap in the same cycle.
//     - IDLE  + start -> RUN, divider=0.
//     - RUN   + start -> PAUSE. Divider holds its value (phase preserved on resume).
//     - PAUSE + start -> RUN, divider resumes from its held value.
//     - DONE  + start -> ignored. Only clear or reset leave DONE.
//     - RUN   + lap   -> toggle disp_hold. Lap is ignored in other states; disp_hold persists into PAUSE/DONE.
//   Divider:
//     - Counts 0..DIV-1 only in RUN; wraps to 0.
//     - tick_en=1 on the cycle the divider equals DIV-1 while in RUN. First tick comes DIV cycles after entering RUN from IDLE.
//     - Terminal count: if STOP_AT_MAX=1 and count_tc=1 at the tick cycle, tick_en is suppressed (stays 0) and next state=DONE.
//       If STOP_AT_MAX=0, the tick is issued normally.
//   All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   Shared package count_pkg: state encoding localparams (ST_IDLE/ST_RUN/ST_PAUSE/ST_DONE), DIV width via $clog2.
//   Sub-module btn_debounce (sync + debounce + edge pulse), instanced three times with DB_CYCLES passed through.
//   FSM, divider and output registers live in count_run_ctrl.
// TESTING  (sim params: CLK_HZ=100, TICK_HZ=10 -> DIV=10, DB_CYCLES=4)
//   1. Reset asserted 3 cycles, buttons low -> state=00, tick_en=count_clr=disp_hold=0; stays so for 50 cycles.
//   2. Clean btn_start held 10 cycles -> state=01 exactly once. tick_en pulses 1 cycle every 10 cycles,
//      first pulse 10 cycles after state=01.
//   3. btn_start toggling every 2 cycles for 30 cycles -> no state change. Then held high 10 cycles -> one IDLE->RUN transition.
//   4. In RUN, press start 3 cycles after a tick -> PAUSE, no tick_en while paused.
//      Press start again -> RUN; first tick 7 cycles after re-entering RUN.
//   5. STOP_AT_MAX=1, count_tc=1 in RUN -> at divider=9, tick_en stays 0 and state=11.
//      Start press ignored. Clear press -> state=00 with count_clr high exactly 1 cycle.
//   6. PAUSE with btn_clear and btn_start debounced on the same cycle -> IDLE, count_clr 1 cycle.
//      Separately, reset asserted mid-RUN with disp_hold=1 -> IDLE, disp_hold=0 at that edge.

Source files
------------

// File: rtl/count_pkg.sv
// Shared types and helpers for the run/pause/clear counter sequencer.
package count_pkg;

  // FSM state encoding, also exported on the state output.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/count_run_ctrl_if.sv
// Button, terminal-count and control-output bundle between the board side
// and the sequencer.
interface count_run_ctrl_if;
  import count_pkg::*;

  logic   btn_start;
  logic   btn_clear;
  logic   btn_lap;
  logic   count_tc;
  logic   tick_en;
  logic   count_clr;
  logic   disp_hold;
  state_t state;

  // Board/datapath side: drives buttons and terminal count, observes controls.
  modport master (
    output btn_start, btn_clear, btn_lap, count_tc,
    input  tick_en, count_clr, disp_hold, state
  );

  // Sequencer side.
  modport slave (
    input  btn_start, btn_clear, btn_lap, count_tc,
    output tick_en, count_clr, disp_hold, state
  );
endinterface

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchronizer, stable-level debounce and a registered
// one-cycle pulse on each accepted press (rising edge of the debounced level).
module btn_debounce
  import count_pkg::*;
#(
  parameter int DB_CYCLES = 500_000
) (
  input  logic clk_50MHz,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int              CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          db;
  logic          db_d;
  logic [CW-1:0] cnt;

  // Bring the asynchronous button into the clock domain.
  // NOTE: every clocked block uses <= so all flops see pre-edge values and
  // the synchronizer stages do not collapse into one.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
    end
  end

  // Accept a new level only after DB_CYCLES consecutive differing samples.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      cnt <= '0;
      db  <= 1'b0;
    end else if (sync2 == db) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      db  <= sync2;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Registered rising-edge detect of the debounced level; releases are ignored.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      db_d  <= 1'b0;
      press <= 1'b0;
    end else begin
      db_d  <= db;
      press <= db & ~db_d;
    end
  end

endmodule

// File: rtl/count_run_ctrl.sv
// Run/pause/clear sequencer for the BCD counter: debounced buttons drive an
// FSM that gates a tick divider and issues clear and display-hold controls.
module count_run_ctrl
  import count_pkg::*;
#(
  parameter int CLK_HZ      = 50_000_000,
  parameter int TICK_HZ     = 1,
  parameter int DB_CYCLES   = 500_000,
  parameter int STOP_AT_MAX = 1
) (
  input  logic             clk_50MHz,
  input  logic             reset,
  count_run_ctrl_if.slave  bus
);

  localparam int            DIV      = CLK_HZ / TICK_HZ;
  localparam int            DW       = cnt_width(DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam bit            STOP     = (STOP_AT_MAX != 0);

  logic          press_start;
  logic          press_clear;
  logic          press_lap;

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic          tick_q, tick_d;
  logic          clr_q, clr_d;
  logic          hold_q, hold_d;
  logic          at_last;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_start (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .btn       (bus.btn_start),
    .press     (press_start)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clear (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .btn       (bus.btn_clear),
    .press     (press_clear)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_lap (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .btn       (bus.btn_lap),
    .press     (press_lap)
  );

  assign at_last = (div_q == DIV_LAST);

  // Next state, divider and output values from the current state and presses.
  // NOTE: every variable gets a default before any branch so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    clr_d   = 1'b0;
    hold_d  = hold_q;

    if (press_clear) begin
      // Clear wins over start/lap arriving in the same cycle.
      state_d = ST_IDLE;
      div_d   = '0;
      clr_d   = 1'b1;
      hold_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_start) begin
            state_d = ST_RUN;
            div_d   = '0;
          end
        end
        ST_RUN: begin
          div_d = at_last ? '0 : div_q + 1'b1;
          if (press_lap) hold_d = ~hold_q;
          if (at_last && STOP && bus.count_tc) begin
            state_d = ST_DONE;
          end else begin
            tick_d = at_last;
            if (press_start) state_d = ST_PAUSE;
          end
        end
        ST_PAUSE: begin
          // Divider keeps its value so the tick phase survives the pause.
          if (press_start) state_d = ST_RUN;
        end
        ST_DONE: begin
          // Only clear or reset leave DONE.
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, divider and registered outputs.
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      tick_q  <= 1'b0;
      clr_q   <= 1'b0;
      hold_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      clr_q   <= clr_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.state     = state_q;
  assign bus.tick_en   = tick_q;
  assign bus.count_clr = clr_q;
  assign bus.disp_hold = hold_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Self-checking bench for count_run_ctrl (DIV=10, DB_CYCLES=4, STOP_AT_MAX=1).
// A cycle-level behavioural model is compared on every falling edge; directed
// scenarios add hand-computed latency and pulse-count expectations.
module tb_count_run_ctrl;

  localparam int DIV  = 10;
  localparam int DB   = 4;
  localparam bit STOP = 1'b1;

  logic clk_50MHz = 1'b0;
  logic reset;

  always #5 clk_50MHz = ~clk_50MHz;

  count_run_ctrl_if bus ();

  count_run_ctrl #(
    .CLK_HZ      (100),
    .TICK_HZ     (10),
    .DB_CYCLES   (DB),
    .STOP_AT_MAX (1)
  ) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .bus       (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Buttons: index 0 start, 1 clear, 2 lap.
  bit           m_s1[3], m_s2[3], m_db[3], m_dbd[3], m_press[3];
  bit [DB-1:0]  m_hist[3];
  int           m_state;
  int           m_run;     // RUN cycles since leaving IDLE
  bit           m_tick, m_clr, m_hold;
  bit           model_ok = 1'b0;

  function automatic bit raw_btn(input int b);
    case (b)
      0:       return bus.btn_start;
      1:       return bus.btn_clear;
      default: return bus.btn_lap;
    endcase
  endfunction

  always @(posedge clk_50MHz) begin
    bit ps, pc, pl, at_last;
    model_ok = 1'b1;
    if (reset) begin
      for (int b = 0; b < 3; b++) begin
        m_s1[b] = 0; m_s2[b] = 0; m_db[b] = 0; m_dbd[b] = 0;
        m_press[b] = 0; m_hist[b] = '0;
      end
      m_state = 0; m_run = 0; m_tick = 0; m_clr = 0; m_hold = 0;
    end else begin
      ps = m_press[0]; pc = m_press[1]; pl = m_press[2];
      m_tick = 0;
      m_clr  = 0;
      if (pc) begin
        m_state = 0; m_run = 0; m_hold = 0; m_clr = 1;
      end else begin
        case (m_state)
          0: if (ps) begin m_state = 1; m_run = 0; end
          1: begin
            // Every DIV-th RUN cycle is a tick slot.
            at_last = ((m_run % DIV) == DIV - 1);
            m_run++;
            if (pl) m_hold = !m_hold;
            if (at_last && STOP && bus.count_tc) m_state = 3;
            else begin
              m_tick = at_last;
              if (ps) m_state = 2;
            end
          end
          2: if (ps) m_state = 1;
          default: ;
        endcase
      end
      for (int b = 0; b < 3; b++) begin
        m_press[b] = m_db[b] & ~m_dbd[b];
        m_dbd[b]   = m_db[b];
        // Level accepted when the last DB synchronized samples all disagree with it.
        m_hist[b]  = {m_hist[b][DB-2:0], m_s2[b]};
        if (m_hist[b] == {DB{!m_db[b]}}) m_db[b] = !m_db[b];
        m_s2[b] = m_s1[b];
        m_s1[b] = raw_btn(b);
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk_50MHz) begin
    if (model_ok) begin
      check("state",     bus.state,     m_state);
      check("tick_en",   bus.tick_en,   m_tick);
      check("count_clr", bus.count_clr, m_clr);
      check("disp_hold", bus.disp_hold, m_hold);
    end
  end

  // ---------------- directed stimulus ----------------
  int first_st[4];
  int n_st[4];
  int first_tick, n_tick, n_clr;

  // Hold the chosen buttons for 'hold' cycles, observe for 'total' cycles.
  task automatic drive(input bit s, input bit c, input bit l, input int hold, input int total);
    first_tick = 0; n_tick = 0; n_clr = 0;
    for (int k = 0; k < 4; k++) begin first_st[k] = 0; n_st[k] = 0; end
    bus.btn_start = s; bus.btn_clear = c; bus.btn_lap = l;
    for (int i = 1; i <= total; i++) begin
      @(negedge clk_50MHz);
      if (first_st[int'(bus.state)] == 0) first_st[int'(bus.state)] = i;
      n_st[int'(bus.state)]++;
      if (bus.tick_en) begin
        n_tick++;
        if (first_tick == 0) first_tick = i;
      end
      if (bus.count_clr) n_clr++;
      if (i == hold) begin
        bus.btn_start = 0; bus.btn_clear = 0; bus.btn_lap = 0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    int bad, n;
    reset = 1'b1;
    bus.btn_start = 0; bus.btn_clear = 0; bus.btn_lap = 0; bus.count_tc = 0;

    // 1. Reset 3 cycles, then quiet idle for 50 cycles.
    repeat (3) @(negedge clk_50MHz);
    reset = 1'b0;
    check("reset_state", bus.state, 0);
    check("reset_hold",  bus.disp_hold, 0);
    bad = 0;
    repeat (50) begin
      @(negedge clk_50MHz);
      if (bus.state != 0 || bus.tick_en || bus.count_clr || bus.disp_hold) bad++;
    end
    check("idle_quiet", bad, 0);

    // 2. Clean start: RUN 8 cycles after press edge, ticks every 10 cycles.
    drive(1, 0, 0, 10, 30);
    check("start_latency", first_st[1], 8);
    check("first_tick",    first_tick, 18);
    check("tick_count",    n_tick, 2);

    // 3. Back to IDLE, bouncy start ignored, then a clean hold starts.
    drive(0, 1, 0, 10, 20);
    check("clr_pulse_3", n_clr, 1);
    check("idle_after_clr", bus.state, 0);
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      bus.btn_start = ((i % 4) >= 2);
      @(negedge clk_50MHz);
      if (bus.state != 0) bad++;
    end
    bus.btn_start = 0;
    check("bounce_ignored", bad, 0);
    drive(1, 0, 0, 10, 20);
    check("bounce_then_hold", first_st[1], 8);

    // 4. Pause 3 cycles after a tick; resume ticks after 7 cycles.
    n = 0;
    while (!bus.tick_en && n < 30) begin
      @(negedge clk_50MHz);
      n++;
    end
    check("tick_found", bus.tick_en, 1);
    repeat (5) @(negedge clk_50MHz);
    drive(1, 0, 0, 10, 20);
    check("pause_latency", first_st[2], 8);
    check("pause_ticks",   n_tick, 1);
    drive(0, 0, 0, 0, 20);
    check("paused_no_tick", n_tick, 0);
    check("paused_state",   n_st[2], 20);
    drive(1, 0, 0, 10, 20);
    check("resume_latency",  first_st[1], 8);
    check("resume_tick_gap", first_tick - first_st[1], 7);

    // 5. Terminal count stops in DONE; start ignored; clear leaves.
    drive(0, 1, 0, 10, 20);
    check("clr_pulse_5a", n_clr, 1);
    bus.count_tc = 1;
    drive(1, 0, 0, 10, 25);
    check("done_gap",   first_st[3] - first_st[1], 10);
    check("done_ticks", n_tick, 0);
    drive(1, 0, 0, 10, 20);
    check("done_holds", n_st[3], 20);
    drive(0, 1, 0, 10, 20);
    check("done_clr_pulse", n_clr, 1);
    check("done_to_idle",   bus.state, 0);
    bus.count_tc = 0;

    // 6a. Clear and start together from PAUSE -> IDLE.
    drive(1, 0, 0, 10, 20);
    drive(1, 0, 0, 10, 20);
    check("in_pause", bus.state, 2);
    drive(1, 1, 0, 10, 20);
    check("both_clr_pulse", n_clr, 1);
    check("both_no_run",    n_st[1], 0);
    check("both_idle",      bus.state, 0);

    // 6b. Lap ignored in IDLE, toggles in RUN; reset mid-RUN clears it.
    drive(0, 0, 1, 10, 20);
    check("lap_idle", bus.disp_hold, 0);
    drive(1, 0, 0, 10, 20);
    drive(0, 0, 1, 10, 20);
    check("lap_run", bus.disp_hold, 1);
    reset = 1'b1;
    @(negedge clk_50MHz);
    check("rst_state", bus.state, 0);
    check("rst_hold",  bus.disp_hold, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk_50MHz);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
